// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the stage sequencer and its stage chain / controller.
//   enable          run request (level)
//   mode_continuous 1 = restart next frame automatically, 0 = single-shot
//   skip_mask       bit i = 1 bypasses stage i
//   timeout_cycles  per-stage watchdog limit, 0 disables it
//   stage_done      per-stage completion
//   stage_enable    one-hot (or zero) enable to the active stage
//   busy            frame in progress
//   frame_done      one-cycle pulse per completed frame
//   error           sticky watchdog flag
//   error_stage     index of the stage that timed out
//   frame_count     completed frames, wraps
// slave = sequencer side, master = controller / stage side.
interface pipeline_sequencer_if #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) ();

  logic                  enable;
  logic                  mode_continuous;
  logic [NUM_STAGES-1:0] skip_mask;
  logic [TIMEOUT_W-1:0]  timeout_cycles;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_enable;
  logic                  busy;
  logic                  frame_done;
  logic                  error;
  logic [IDX_W-1:0]      error_stage;
  logic [15:0]           frame_count;

  modport slave (
    input  enable, mode_continuous, skip_mask, timeout_cycles, stage_done,
    output stage_enable, busy, frame_done, error, error_stage, frame_count
  );

  modport master (
    output enable, mode_continuous, skip_mask, timeout_cycles, stage_done,
    input  stage_enable, busy, frame_done, error, error_stage, frame_count
  );

endinterface

// File: rtl/pipeline_sequencer.sv
// Stage sequencer for the edge-detection pipeline. Steps NUM_STAGES stages through an
// enable/done handshake with a per-stage skip mask, single-shot or continuous frames,
// a per-stage timeout watchdog with sticky error capture and a frame counter.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    pipeline_sequencer_if.slave (see interface for signal list)
// All outputs are registered.
module pipeline_sequencer #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                clk,
  input  logic                reset,
  pipeline_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRun, StDone, StHold, StError} state_e;

  localparam logic [NUM_STAGES-1:0] StageOne = NUM_STAGES'(1);

  state_e                state_q;
  logic [IDX_W-1:0]      cur_q;
  logic [NUM_STAGES-1:0] skip_q;
  logic [TIMEOUT_W-1:0]  timeout_q;
  logic                  cont_q;
  logic [TIMEOUT_W-1:0]  wdog_q;

  logic [NUM_STAGES-1:0] stage_enable_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  error_q;
  logic [IDX_W-1:0]      error_stage_q;
  logic [15:0]           frame_count_q;

  // First unskipped stage of the live mask (used only when a frame starts).
  logic             start_found;
  logic [IDX_W-1:0] start_idx;
  // Next unskipped stage above cur under the latched mask.
  logic             next_found;
  logic [IDX_W-1:0] next_idx;

  always_comb begin
    start_found = 1'b0;
    start_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    // Scan downward so the lowest qualifying index is the last one written.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bus.skip_mask[i]) begin
        start_found = 1'b1;
        start_idx   = IDX_W'(i);
      end
      if (!skip_q[i] && (IDX_W'(i) > cur_q)) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  logic cur_done;
  assign cur_done = bus.stage_done[cur_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cur_q          <= '0;
      skip_q         <= '0;
      timeout_q      <= '0;
      cont_q         <= 1'b0;
      wdog_q         <= '0;
      stage_enable_q <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      error_q        <= 1'b0;
      error_stage_q  <= '0;
      frame_count_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.enable) begin
            skip_q    <= bus.skip_mask;
            timeout_q <= bus.timeout_cycles;
            cont_q    <= bus.mode_continuous;
            if (start_found) begin
              state_q        <= StRun;
              cur_q          <= start_idx;
              stage_enable_q <= StageOne << start_idx;
              busy_q         <= 1'b1;
              wdog_q         <= '0;
            end else begin
              // Everything skipped: the frame completes immediately.
              state_q       <= StDone;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end
          end
        end

        StRun: begin
          if (!bus.enable) begin
            state_q        <= StIdle;
            stage_enable_q <= '0;
            busy_q         <= 1'b0;
          end else if (cur_done) begin
            // Done takes priority over a coincident watchdog expiry.
            if (next_found) begin
              cur_q          <= next_idx;
              stage_enable_q <= StageOne << next_idx;
              wdog_q         <= '0;
            end else begin
              state_q        <= StDone;
              stage_enable_q <= '0;
              busy_q         <= 1'b0;
              frame_done_q   <= 1'b1;
              frame_count_q  <= frame_count_q + 16'd1;
            end
          end else if ((timeout_q != '0) && (wdog_q == timeout_q - TIMEOUT_W'(1))) begin
            // This is the T-th enabled cycle without done.
            state_q        <= StError;
            stage_enable_q <= '0;
            busy_q         <= 1'b0;
            error_q        <= 1'b1;
            error_stage_q  <= cur_q;
          end else begin
            wdog_q <= wdog_q + TIMEOUT_W'(1);
          end
        end

        StDone: begin
          if (bus.enable && cont_q) begin
            skip_q    <= bus.skip_mask;
            timeout_q <= bus.timeout_cycles;
            cont_q    <= bus.mode_continuous;
            if (start_found) begin
              state_q        <= StRun;
              cur_q          <= start_idx;
              stage_enable_q <= StageOne << start_idx;
              busy_q         <= 1'b1;
              wdog_q         <= '0;
            end else begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end
          end else if (bus.enable) begin
            state_q <= StHold;
          end else begin
            state_q <= StIdle;
          end
        end

        StHold: begin
          if (!bus.enable) state_q <= StIdle;
        end

        StError: begin
          if (!bus.enable) state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.stage_enable = stage_enable_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.error        = error_q;
  assign bus.error_stage  = error_stage_q;
  assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a stage responder raises done a fixed number of
// cycles after each enable, and a monitor records the order of enabled stages.
module tb_pipeline_sequencer;

  logic clk;
  logic reset;

  pipeline_sequencer_if #(.NUM_STAGES(6), .TIMEOUT_W(16)) bus ();

  pipeline_sequencer #(.NUM_STAGES(6), .TIMEOUT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Responder controls: done appears lat cycles after the stage enable rises.
  int         lat       = 2;
  logic [5:0] dead_mask = '0;

  // Monitor results.
  int          fd_cnt  = 0;
  logic [31:0] seq     = '0;
  int          nseq    = 0;
  bit          hot_bad = 1'b0;

  int cnt3;
  int fd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stage responder, updated at the falling edge so done is stable at the next rising edge.
  initial begin
    logic [5:0] prev;
    int         cnt;
    prev = '0;
    cnt  = 0;
    bus.stage_done = '0;
    forever begin
      @(negedge clk);
      if (bus.stage_enable != '0 && bus.stage_enable == prev) cnt++;
      else cnt = 0;
      prev = bus.stage_enable;
      if (bus.stage_enable != '0 && cnt == lat && (bus.stage_enable & dead_mask) == '0)
        bus.stage_done = bus.stage_enable;
      else
        bus.stage_done = '0;
    end
  end

  // Monitor: counts frame_done cycles and logs each newly enabled stage as a nibble.
  initial begin
    logic [5:0] mprev;
    mprev = '0;
    forever begin
      @(negedge clk);
      if (bus.frame_done) fd_cnt++;
      if ($countones(bus.stage_enable) > 1) hot_bad = 1'b1;
      if (bus.stage_enable != '0 && bus.stage_enable != mprev) begin
        for (int i = 0; i < 6; i++)
          if (bus.stage_enable[i]) seq = {seq[27:0], 4'(i)};
        nseq++;
      end
      mprev = bus.stage_enable;
    end
  end

  task automatic clear_log();
    seq  = '0;
    nseq = 0;
  endtask

  initial begin
    reset               = 1'b1;
    bus.enable          = 1'b0;
    bus.mode_continuous = 1'b0;
    bus.skip_mask       = '0;
    bus.timeout_cycles  = '0;
    tick(3);
    check("rst_stage_enable", 32'(bus.stage_enable), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_error", 32'(bus.error), 0);
    check("rst_error_stage", 32'(bus.error_stage), 0);
    check("rst_frame_count", 32'(bus.frame_count), 0);
    reset = 1'b0;
    tick(2);

    // Single-shot, all stages, latency 2.
    clear_log();
    fd0 = fd_cnt;
    bus.enable = 1'b1;
    tick();
    check("ss_first_enable", 32'(bus.stage_enable), 32'h01);
    check("ss_busy", 32'(bus.busy), 1);
    tick(18);
    check("ss_frame_done", 32'(bus.frame_done), 1);
    check("ss_done_no_enable", 32'(bus.stage_enable), 0);
    check("ss_frame_count", 32'(bus.frame_count), 1);
    tick(5);
    check("ss_seq", seq, 32'h012345);
    check("ss_seq_len", 32'(nseq), 6);
    check("ss_hold_enable", 32'(bus.stage_enable), 0);
    check("ss_hold_busy", 32'(bus.busy), 0);
    check("ss_one_pulse", 32'(fd_cnt - fd0), 1);
    bus.enable = 1'b0;
    tick(2);

    // Skip stages 1 and 4; a mid-frame mask change must be ignored.
    clear_log();
    bus.skip_mask = 6'b010010;
    bus.enable    = 1'b1;
    tick();
    bus.skip_mask = 6'b000000;
    check("skip_first", 32'(bus.stage_enable), 32'h01);
    tick(12);
    check("skip_frame_done", 32'(bus.frame_done), 1);
    check("skip_frame_count", 32'(bus.frame_count), 2);
    bus.enable = 1'b0;
    tick(2);
    check("skip_seq", seq, 32'h0235);

    // Continuous mode, three frames.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mode_continuous = 1'b1;
    bus.enable          = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      tick(18);
      check($sformatf("cont_fd_%0d", f), 32'(bus.frame_done), 1);
      if (f < 2) begin
        tick();
        check($sformatf("cont_restart_%0d", f), 32'(bus.stage_enable), 32'h01);
      end
    end
    bus.enable = 1'b0;
    tick();
    check("cont_count", 32'(bus.frame_count), 3);
    check("cont_stop_enable", 32'(bus.stage_enable), 0);
    bus.mode_continuous = 1'b0;
    tick();

    // All stages skipped: no enables, frame_done per start.
    clear_log();
    bus.skip_mask = 6'h3F;
    bus.enable    = 1'b1;
    tick();
    check("allskip_fd", 32'(bus.frame_done), 1);
    check("allskip_count", 32'(bus.frame_count), 4);
    tick();
    check("allskip_hold_fd", 32'(bus.frame_done), 0);
    bus.enable = 1'b0;
    tick(2);
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    check("wrap_preset", 32'(bus.frame_count), 32'hFFFF);
    bus.enable = 1'b1;
    tick();
    check("wrap_count", 32'(bus.frame_count), 0);
    bus.enable = 1'b0;
    tick(2);
    bus.enable = 1'b1;
    tick();
    check("wrap_next", 32'(bus.frame_count), 1);
    bus.enable = 1'b0;
    tick(2);
    check("allskip_nseq", 32'(nseq), 0);
    bus.skip_mask = '0;

    // Watchdog: stage 3 never responds.
    bus.timeout_cycles = 16'd8;
    dead_mask          = 6'b001000;
    bus.enable         = 1'b1;
    cnt3               = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.stage_enable[3]) cnt3++;
      if (bus.error) break;
    end
    check("tmo_en_cycles", 32'(cnt3), 8);
    check("tmo_error", 32'(bus.error), 1);
    check("tmo_error_stage", 32'(bus.error_stage), 3);
    check("tmo_busy", 32'(bus.busy), 0);
    check("tmo_enable", 32'(bus.stage_enable), 0);
    bus.enable = 1'b0;
    dead_mask  = '0;
    bus.timeout_cycles = '0;
    tick(2);
    check("tmo_sticky", 32'(bus.error), 1);
    check("tmo_sticky_stage", 32'(bus.error_stage), 3);

    // Abort during stage 2.
    fd0 = fd_cnt;
    bus.enable = 1'b1;
    tick();
    tick(6);
    check("abort_at_s2", 32'(bus.stage_enable), 32'h04);
    bus.enable = 1'b0;
    tick();
    check("abort_enable", 32'(bus.stage_enable), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_fd", 32'(bus.frame_done), 0);
    tick(3);
    check("abort_no_pulse", 32'(fd_cnt - fd0), 0);
    check("abort_count", 32'(bus.frame_count), 1);

    // Reset during stage 4.
    bus.enable = 1'b1;
    tick();
    tick(12);
    check("rst_mid_at_s4", 32'(bus.stage_enable), 32'h10);
    reset = 1'b1;
    tick();
    check("rst_mid_enable", 32'(bus.stage_enable), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_error", 32'(bus.error), 0);
    check("rst_mid_error_stage", 32'(bus.error_stage), 0);
    check("rst_mid_count", 32'(bus.frame_count), 0);
    reset      = 1'b0;
    bus.enable = 1'b0;
    tick(2);

    // Done on the 8th enabled cycle beats an 8-cycle timeout.
    bus.timeout_cycles = 16'd8;
    lat                = 7;
    bus.enable         = 1'b1;
    tick();
    tick(48);
    check("edge_fd", 32'(bus.frame_done), 1);
    check("edge_error", 32'(bus.error), 0);
    check("edge_count", 32'(bus.frame_count), 1);
    bus.enable = 1'b0;
    tick(2);

    check("one_hot", 32'(hot_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
